console_merge: RTL and testbench
================================

// Module: console_merge
// PURPOSE
//  Downstream of comm: consumes its 16-bit enable mask (enabled_out) and merges bytes
//  from per-console uart_rx instances into one host-bound byte stream for a uart_tx.
//  Each console has a one-byte holding register. A round-robin arbiter serialises
//  bytes from enabled consoles, optionally prefixing each byte with a channel tag.
// PARAMETERS
//  NUM_CH    16     number of console channels; must match the comm mask width, 1..128
//  TAG_BASE  8'h80  tag byte = TAG_BASE | channel index (used only with CONSOLE_TAG_EN)
// PORTS
//  clk           in   1         system clock; all logic on posedge
//  rst           in   1         synchronous, active-high reset
//  enable_mask   in   NUM_CH    from comm enabled_out; bit i=1 forwards channel i
//  ch_valid      in   NUM_CH    per-channel uart_rx ready, 1-cycle pulse per byte
//  ch_data       in   NUM_CH*8  channel i byte at [i*8+:8]; valid with ch_valid[i]
//  tx_data       out  8         byte to uart_tx; stable from tx_start until tx_done
//  tx_start      out  1         1-cycle pulse requesting uart_tx to send tx_data
//  tx_done       in   1         1-cycle pulse from uart_tx: byte fully shifted out
//  ovf_clear     in   1         clears ovf_flags (all bits)
//  ovf_flags     out  NUM_CH    sticky per-channel overflow (byte dropped)
//  busy          out  1         1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: tx_data=0, tx_start=0, busy=0, ovf_flags=0, all holding regs empty,
//   rr pointer=0, FSM=IDLE. Reset mid-transfer abandons the transfer; a tx_done that
//   arrives afterwards in IDLE is ignored.
//  Capture: ch_valid[i]=1 and enable_mask[i]=1 with hold[i] empty -> hold[i] loaded.
//   If hold[i] is full and not granted in the same cycle, the new byte is dropped
//   and ovf_flags[i] is set. Grant-clear and capture in the same cycle -> capture wins
//   and hold[i] stays full with the new byte. ch_valid[i] with enable_mask[i]=0 is ignored.
//  Disable: enable_mask[i] 1->0 empties hold[i] on the next edge unless i is being
//   transmitted. An in-flight byte always completes.
//  Arbitration: in IDLE, choose the first full hold[j] with enable_mask[j]=1, searching
//   from rr_ptr upward with wrap NUM_CH-1 -> 0. On grant: hold[j] is emptied and
//   rr_ptr <= (j+1) mod NUM_CH.
//  FSM: IDLE -> (grant) SEND_TAG [tag en] | SEND_DATA; SEND_x: tx_start=1 for exactly
//   1 cycle with tx_data set -> WAIT_x; WAIT_TAG -(tx_done)-> SEND_DATA;
//   WAIT_DATA -(tx_done)-> IDLE. tx_done outside WAIT_x is ignored.
//  Latency: a byte captured at edge k, in IDLE, gives tx_start=1 in cycle k+2
//   (grant at edge k+1, pulse registered at edge k+2). Back-to-back transfers: IDLE
//   lasts 1 cycle after tx_done.
//  ovf_clear and a simultaneous new overflow -> the flag ends up set (set wins).
// CONFIGURATION
//  `CONSOLE_TAG_EN defined: each forwarded byte is a 2-byte frame,
//   {TAG_BASE|idx[6:0]} then data. Undefined: SEND_TAG/WAIT_TAG are absent and only
//   the raw data byte is sent; the host can tell channels apart only through the mask.
// STRUCTURE
//  console_mux_pkg: FSM state enum (IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA),
//   BYTE_W=8, default TAG_BASE and NUM_CH constants; shared with comm.
//  Sub-module rr_arbiter #(N): req[N], ptr -> gnt_valid, gnt_idx. Purely combinational
//   search; rr_ptr itself lives in console_merge.
// TESTING (uart_tx/uart_rx loopback, CLK_PER_BIT=16, NUM_CH=16)
//  1 mask=16'h0001, ch0 sends 8'h41 -> host receives 8'h80,8'h41 (tag en) or 8'h41;
//    ovf_flags=0.
//  2 mask=16'hFFFF, ch3=8'h33 and ch7=8'h77 in same cycle, rr_ptr=0 -> order ch3 then
//    ch7; next request from ch3 loses to ch5 if both are pending.
//  3 mask=16'h0004, ch2 sends 3 bytes 1 cycle apart while busy -> first and second
//    forwarded, third dropped, ovf_flags=16'h0004; ovf_clear -> 0.
//  4 mask=16'h0002, ch1=8'h11 pending; mask->0 before grant -> nothing sent.
//    Same mask clear during WAIT_DATA -> byte completes.
//  5 rst pulsed during WAIT_DATA -> tx_start=0, busy=0 next cycle; later tx_done
//    ignored; no extra byte sent.
//  6 ch15 and ch0 pending, rr_ptr=15 -> ch15 first, then ch0 (wrap-around).

Source files
------------

// File: rtl/console_mux_pkg.sv
// Constants and FSM state type shared by the console merger and comm.
package console_mux_pkg;

  localparam int         BYTE_W       = 8;
  localparam int         NUM_CH_DEF   = 16;
  localparam logic [7:0] TAG_BASE_DEF = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SEND_TAG,
    WAIT_TAG,
    SEND_DATA,
    WAIT_DATA
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // The second pass overrides the first, so a hit at or above ptr takes priority over wrap.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/console_merge.sv
// Merges per-console rx bytes into one round-robin tx byte stream.
// Define CONSOLE_TAG_EN to prefix every forwarded byte with a channel tag byte.
//
// state     | meaning
// IDLE      | waiting for a full, enabled holding register
// SEND_TAG  | registering tag byte and tx_start pulse
// WAIT_TAG  | tag byte shifting out, waiting for tx_done
// SEND_DATA | registering data byte and tx_start pulse
// WAIT_DATA | data byte shifting out, waiting for tx_done
module console_merge
  import console_mux_pkg::*;
#(
  parameter int         NUM_CH   = NUM_CH_DEF,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        enable_mask,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*BYTE_W-1:0] ch_data,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  input  logic                     ovf_clear,
  output logic [NUM_CH-1:0]        ovf_flags,
  output logic                     busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                          state_q;
  logic [PTR_W-1:0]                rr_ptr_q;
  logic [BYTE_W-1:0]               cur_data_q;
  logic [BYTE_W-1:0]               tx_data_q;
  logic                            tx_start_q;
`ifdef CONSOLE_TAG_EN
  logic [6:0]                      cur_idx_q;
`endif

  logic [NUM_CH-1:0]               hold_full_q, hold_full_d;
  logic [NUM_CH-1:0][BYTE_W-1:0]   hold_data_q, hold_data_d;
  logic [NUM_CH-1:0]               ovf_q, ovf_d;

  logic                            gnt_valid;
  logic [PTR_W-1:0]                gnt_idx;
  logic                            grant;
  logic [NUM_CH-1:0]               gnt_vec;

  rr_arbiter #(.N(NUM_CH), .IW(PTR_W)) u_arb (
    .req       (hold_full_q & enable_mask),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant   = (state_q == IDLE) && gnt_valid;
  assign gnt_vec = grant ? (NUM_CH'(1) << gnt_idx) : '0;

  // Grant empties the slot first so a same-cycle capture refills it instead of overflowing.
  always_comb begin
    hold_full_d = hold_full_q & ~gnt_vec;
    hold_data_d = hold_data_q;
    ovf_d       = ovf_clear ? '0 : ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enable_mask[i]) begin
        hold_full_d[i] = 1'b0;
      end else if (ch_valid[i]) begin
        if (!hold_full_d[i]) begin
          hold_full_d[i] = 1'b1;
          hold_data_d[i] = ch_data[i*BYTE_W +: BYTE_W];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= '0;
      hold_data_q <= '0;
      ovf_q       <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_data_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef CONSOLE_TAG_EN
      cur_idx_q  <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            cur_data_q <= hold_data_q[gnt_idx];
            rr_ptr_q   <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
`ifdef CONSOLE_TAG_EN
            cur_idx_q  <= 7'(gnt_idx);
            state_q    <= SEND_TAG;
`else
            state_q    <= SEND_DATA;
`endif
          end
        end
`ifdef CONSOLE_TAG_EN
        SEND_TAG: begin
          tx_data_q  <= TAG_BASE | {1'b0, cur_idx_q};
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TAG;
        end
        WAIT_TAG: begin
          if (tx_done) state_q <= SEND_DATA;
        end
`endif
        SEND_DATA: begin
          tx_data_q  <= cur_data_q;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (tx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign ovf_flags = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_console_merge.sv
// Randomized bench for console_merge against a transaction-level reference model.
module tb_console_merge;

  localparam int NCH = 16;
  localparam int PH_IDLE = 0, PH_STAG = 1, PH_WTAG = 2, PH_SDAT = 3, PH_WDAT = 4;
`ifdef CONSOLE_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  enable_mask, ch_valid, ovf_flags;
  logic [127:0] ch_data;
  logic [7:0]   tx_data;
  logic         tx_start, tx_done, ovf_clear, busy;

  console_merge #(.NUM_CH(NCH), .TAG_BASE(8'h80)) dut (
    .clk(clk), .rst(rst), .enable_mask(enable_mask), .ch_valid(ch_valid),
    .ch_data(ch_data), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .ovf_clear(ovf_clear), .ovf_flags(ovf_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [15:0] m_full, m_ovf;
  logic [7:0]  m_data [NCH];
  int          m_rr, m_ph, m_idx;
  logic [7:0]  m_cur, m_txd;
  logic        m_txs;
  logic [7:0]  m_sent [$];
  logic [7:0]  exp_q [$];

  int rcnt = -1;
  bit auto_done = 1'b1, spur_en = 1'b0, cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One edge of the reference behaviour, from the inputs present at that edge.
  task automatic model_step();
    int g;
    if (rst) begin
      m_full = '0; m_ovf = '0; m_rr = 0; m_ph = PH_IDLE;
      m_txs = 1'b0; m_txd = '0; m_cur = '0; m_idx = 0;
      for (int i = 0; i < NCH; i++) m_data[i] = '0;
      return;
    end
    g = -1;
    if (m_ph == PH_IDLE)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && m_full[(m_rr + k) % NCH] && enable_mask[(m_rr + k) % NCH])
          g = (m_rr + k) % NCH;
    m_txs = 1'b0;
    case (m_ph)
      PH_IDLE: if (g >= 0) begin
        m_cur = m_data[g]; m_idx = g; m_rr = (g + 1) % NCH;
        m_ph = TAG_ON ? PH_STAG : PH_SDAT;
      end
      PH_STAG: begin
        m_txd = 8'h80 | 8'(m_idx); m_txs = 1'b1; m_sent.push_back(m_txd); m_ph = PH_WTAG;
      end
      PH_WTAG: if (tx_done) m_ph = PH_SDAT;
      PH_SDAT: begin
        m_txd = m_cur; m_txs = 1'b1; m_sent.push_back(m_txd); m_ph = PH_WDAT;
      end
      PH_WDAT: if (tx_done) m_ph = PH_IDLE;
      default: ;
    endcase
    if (ovf_clear) m_ovf = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == i) m_full[i] = 1'b0;
      if (!enable_mask[i]) m_full[i] = 1'b0;
      else if (ch_valid[i]) begin
        if (!m_full[i]) begin
          m_full[i] = 1'b1; m_data[i] = ch_data[i*8 +: 8];
        end else m_ovf[i] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("tx_start", 32'(tx_start), 32'(m_txs));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("busy", 32'(busy), 32'(m_ph != PH_IDLE));
    chk("ovf_flags", 32'(ovf_flags), 32'(m_ovf));
  end

  // Advance one clock; also plays the uart_tx side (tx_done some cycles after tx_start).
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    ch_valid = '0; ovf_clear = 1'b0; tx_done = 1'b0;
    if (rst) rcnt = -1;
    else if (rcnt > 0) rcnt--;
    else if (rcnt == 0) begin tx_done = auto_done; rcnt = -1; end
    else if (spur_en && $urandom_range(0, 19) == 0) tx_done = 1'b1;
    if (!rst && tx_start && auto_done) rcnt = $urandom_range(1, 6);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_ph != PH_IDLE || (m_full & enable_mask) != 0) && n < budget) begin
      tick(); n++;
    end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL drain_timeout waited=%0d limit=%0d", n, budget); end
    repeat (2) tick();
  endtask

  task automatic wait_ph(input int ph, input int budget);
    int n = 0;
    while (m_ph != ph && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL wait_phase_timeout phase=%0d limit=%0d", ph, budget); end
  endtask

  task automatic expect_byte(input int ch, input logic [7:0] b);
    if (TAG_ON) exp_q.push_back(8'h80 | 8'(ch));
    exp_q.push_back(b);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, 32'(m_sent.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({nm, "_byte"}, (i < m_sent.size()) ? 32'(m_sent[i]) : 32'hDEAD, 32'(exp_q[i]));
    m_sent.delete(); exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable_mask = '0; ch_valid = '0; ch_data = '0; tx_done = 1'b0; ovf_clear = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf_flags), 32'h0);
    rst = 1'b0; tick();

    // single byte, latency k+2
    m_sent.delete(); exp_q.delete();
    enable_mask = 16'h0001; tick();
    ch_valid[0] = 1'b1; ch_data[7:0] = 8'h41; tick();
    chk("s1_idle_after_capture", 32'(busy), 32'h0);
    tick();
    chk("s1_busy_after_grant", 32'(busy), 32'h1);
    chk("s1_no_early_start", 32'(tx_start), 32'h0);
    tick();
    chk("s1_latency", 32'(tx_start), 32'h1);
    chk("s1_first_byte", 32'(tx_data), TAG_ON ? 32'h80 : 32'h41);
    drain(200);
    expect_byte(0, 8'h41);
    check_log("s1");
    chk("s1_ovf", 32'(m_ovf), 32'h0);

    // round-robin order: 3,7 then a re-request from 3 loses to 5
    enable_mask = 16'hFFFF;
    ch_valid[3] = 1'b1; ch_valid[7] = 1'b1;
    ch_data[3*8 +: 8] = 8'h33; ch_data[7*8 +: 8] = 8'h77; tick();
    tick();
    ch_valid[3] = 1'b1; ch_valid[5] = 1'b1;
    ch_data[3*8 +: 8] = 8'h3A; ch_data[5*8 +: 8] = 8'h55; tick();
    drain(400);
    expect_byte(3, 8'h33); expect_byte(5, 8'h55); expect_byte(7, 8'h77); expect_byte(3, 8'h3A);
    check_log("s2");

    // overflow on the third back-to-back byte, then clear
    enable_mask = 16'h0004; tick();
    ch_valid[2] = 1'b1; ch_data[2*8 +: 8] = 8'hA1; tick();
    ch_valid[2] = 1'b1; ch_data[2*8 +: 8] = 8'hA2; tick();
    ch_valid[2] = 1'b1; ch_data[2*8 +: 8] = 8'hA3; tick();
    chk("s3_ovf_set", 32'(m_ovf), 32'h0004);
    drain(300);
    expect_byte(2, 8'hA1); expect_byte(2, 8'hA2);
    check_log("s3");
    ovf_clear = 1'b1; tick();
    chk("s3_ovf_cleared", 32'(m_ovf), 32'h0);

    // disable before grant drops the byte; disable in flight lets it finish
    enable_mask = 16'h0002; tick();
    ch_valid[1] = 1'b1; ch_data[1*8 +: 8] = 8'h11; tick();
    enable_mask = 16'h0000; tick();
    enable_mask = 16'h0002; repeat (4) tick();
    chk("s4_dropped_len", 32'(m_sent.size()), 32'h0);
    ch_valid[1] = 1'b1; ch_data[1*8 +: 8] = 8'h12; tick();
    wait_ph(PH_WDAT, 60);
    enable_mask = 16'h0000;
    drain(200);
    expect_byte(1, 8'h12);
    check_log("s4");

    // reset during WAIT_DATA; stray tx_done afterwards
    enable_mask = 16'h0001;
    ch_valid[0] = 1'b1; ch_data[7:0] = 8'h5A; tick();
    wait_ph(PH_WDAT, 60);
    auto_done = 1'b0; rcnt = -1; tx_done = 1'b0;
    tick();
    m_sent.delete(); exp_q.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s5_start_after_rst", 32'(tx_start), 32'h0);
    chk("s5_busy_after_rst", 32'(busy), 32'h0);
    tx_done = 1'b1; tick();
    repeat (10) tick();
    chk("s5_nothing_sent", 32'(m_sent.size()), 32'h0);
    chk("s5_still_idle", 32'(busy), 32'h0);
    auto_done = 1'b1;

    // wrap-around from rr_ptr=15
    enable_mask = 16'hFFFF;
    ch_valid[14] = 1'b1; ch_data[14*8 +: 8] = 8'hE4; tick();
    drain(200);
    m_sent.delete(); exp_q.delete();
    chk("s6_rr_at_15", 32'(m_rr), 32'd15);
    ch_valid[15] = 1'b1; ch_valid[0] = 1'b1;
    ch_data[15*8 +: 8] = 8'hF5; ch_data[7:0] = 8'h05; tick();
    drain(300);
    expect_byte(15, 8'hF5); expect_byte(0, 8'h05);
    check_log("s6");

    // random traffic, mask changes, clears, stray tx_done, occasional reset
    spur_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) enable_mask = 16'($urandom);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 11) == 0) begin
          ch_valid[i] = 1'b1; ch_data[i*8 +: 8] = 8'($urandom);
        end
      ovf_clear = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; spur_en = 1'b0;
    drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
